// File: rtl/load_ctrl_pkg.sv
// Shared definitions for the serial memory loader: operating-mode encodings,
// controller state enum and default geometry.
package load_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_LOAD_I = 2'b01;
  localparam logic [1:0] MODE_LOAD_D = 2'b10;
  localparam logic [1:0] MODE_RUN    = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WRITE,
    LDONE,
    RUN,
    HALTED
  } state_e;

  function automatic logic is_load_mode(input logic [1:0] m);
    return (m == MODE_LOAD_I) || (m == MODE_LOAD_D);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for signals arriving from outside the clk domain.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/load_ctrl.sv
// Serial loader for instruction/data memories plus processor run/halt control.
// mode and mosi are resynchronised; every decision uses the synchronised copies.
module load_ctrl
  import load_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              mosi,
  input  logic              cpu_halt,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_en,
  output logic              done
);

  localparam int                CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [1:0]        m_s;
  logic              mosi_s;

  state_e            state_q,     state_d;
  logic [DATA_W-1:0] shreg_q,     shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [1:0]        sess_mode_q, sess_mode_d;
  logic              mem_sel_q,   mem_sel_d;
  logic              mem_we_q,    mem_we_d;
  logic              cpu_en_q,    cpu_en_d;
  logic              done_q,      done_d;
  logic              mode_changed;

  sync2 #(.WIDTH(2)) u_mode_sync (
    .clk (clk),
    .rst (rst),
    .d   (mode),
    .q   (m_s)
  );

  sync2 #(.WIDTH(1)) u_mosi_sync (
    .clk (clk),
    .rst (rst),
    .d   (mosi),
    .q   (mosi_s)
  );

  // A load session remembers the mode it started in; any difference ends it.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    addr_d       = addr_q;
    sess_mode_d  = sess_mode_q;
    mem_sel_d    = mem_sel_q;
    mode_changed = (m_s != sess_mode_q);

    case (state_q)
      IDLE: begin
        if (is_load_mode(m_s)) begin
          state_d     = SHIFT;
          bit_cnt_d   = '0;
          addr_d      = '0;
          sess_mode_d = m_s;
          mem_sel_d   = m_s[1];
        end else if (m_s == MODE_RUN) begin
          state_d = RUN;
        end
      end
      SHIFT: begin
        if (mode_changed) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          addr_d    = '0;
        end else begin
          shreg_d   = {shreg_q[DATA_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_LAST) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // The strobe for this word is already on the output; leaving cannot cancel it.
        if (mode_changed) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          addr_d    = '0;
        end else if (addr_q == ADDR_LAST) begin
          state_d = LDONE;
        end else begin
          state_d   = SHIFT;
          addr_d    = addr_q + ADDR_W'(1);
          bit_cnt_d = '0;
        end
      end
      LDONE: begin
        if (mode_changed) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          addr_d    = '0;
        end
      end
      RUN: begin
        if (m_s != MODE_RUN) begin
          state_d = IDLE;
        end else if (cpu_halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (m_s != MODE_RUN) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they leave a flop cleanly.
    mem_we_d = (state_d == WRITE);
    cpu_en_d = (state_d == RUN);
    done_d   = (state_d == LDONE) || (state_d == HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      sess_mode_q <= MODE_IDLE;
      mem_sel_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_en_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      sess_mode_q <= sess_mode_d;
      mem_sel_q   <= mem_sel_d;
      mem_we_q    <= mem_we_d;
      cpu_en_q    <= cpu_en_d;
      done_q      <= done_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = shreg_q;
  assign cpu_en    = cpu_en_q;
  assign done      = done_q;

endmodule

// File: tb/tb_load_ctrl.sv
// Self-checking bench for load_ctrl: table-driven single-word loads, hand-built
// corner sequences and randomised sessions scored against a frame-level model.
module tb_load_ctrl;
  import load_ctrl_pkg::*;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int SYNC_LAT   = 2;
  localparam int FRAME_BITS = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic              mosi;
  logic              cpu_halt;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_en;
  logic              done;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] frame_data [DEPTH];

  typedef struct {
    int                cyc;
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t we_q[$];
  wr_t mon_w;

  typedef struct {
    logic [1:0]        mode;
    logic [DATA_W-1:0] word;
    logic              exp_sel;
    logic [DATA_W-1:0] exp_data;
    int                exp_lat;
  } vec_t;

  vec_t vecs [4];

  load_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .mosi      (mosi),
    .cpu_halt  (cpu_halt),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_en    (cpu_en),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed write strobe is logged with the cycle it was seen in
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      mon_w.cyc  = cyc;
      mon_w.sel  = mem_sel;
      mon_w.addr = mem_addr;
      mon_w.data = mem_wdata;
      we_q.push_back(mon_w);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_we"},    int'(mem_we),    0);
    checkOutput({tag, "_mem_sel"},   int'(mem_sel),   0);
    checkOutput({tag, "_mem_addr"},  int'(mem_addr),  0);
    checkOutput({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    checkOutput({tag, "_cpu_en"},    int'(cpu_en),    0);
    checkOutput({tag, "_done"},      int'(done),      0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mode     = MODE_IDLE;
      mosi     = 1'b0;
      cpu_halt = 1'b0;
    end
  endtask

  // One load session: offset o=1.. carries frame bits (MSB first, then one idle
  // bit); from offset k on (k>0) the mode is dropped to IDLE. Frame f is written
  // only if its last data bit reached the FSM before the mode change did.
  task automatic applyStimulus(input logic [1:0] m, input int nf, input int k, output int r);
    int total, n_exp, f, b;
    logic [1:0] cur;
    idleCycles(4);
    we_q.delete();
    @(negedge clk);
    r    = cyc + 1;
    mode = m;
    mosi = 1'($urandom);
    cur  = m;
    total = FRAME_BITS * nf;
    for (int o = 1; o <= total; o++) begin
      @(negedge clk);
      if (k != 0 && o >= k) cur = MODE_IDLE;
      f    = (o - 1) / FRAME_BITS;
      b    = (o - 1) % FRAME_BITS;
      mode = cur;
      mosi = (b < DATA_W) ? frame_data[f][DATA_W-1-b] : 1'($urandom);
    end
    if (k == 0 && nf == DEPTH) begin
      repeat (4) @(negedge clk);
      checkOutput("done_after_full_load", int'(done), 1);
      checkOutput("cpu_en_during_ldone", int'(cpu_en), 0);
    end
    idleCycles(8);
    checkOutput("done_after_session", int'(done), 0);

    n_exp = 0;
    for (int ff = 0; ff < nf; ff++) begin
      if (k == 0 || k > DATA_W + FRAME_BITS * ff) n_exp++;
    end
    checkOutput("write_count", we_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < we_q.size(); i++) begin
      checkOutput($sformatf("write%0d_cycle", i), we_q[i].cyc - r,
                  SYNC_LAT + DATA_W + FRAME_BITS * i);
      checkOutput($sformatf("write%0d_sel", i), int'(we_q[i].sel), (m == MODE_LOAD_D) ? 1 : 0);
      checkOutput($sformatf("write%0d_addr", i), int'(we_q[i].addr), i);
      checkOutput($sformatf("write%0d_data", i), int'(we_q[i].data), int'(frame_data[i]));
    end
  endtask

  // RUN for run_len cycles, optional one-cycle halt pulse at halt_off, then leave
  task automatic runCpu(input int halt_off, input int run_len);
    int r, z, h, n;
    idleCycles(4);
    @(negedge clk);
    r        = cyc + 1;
    mode     = MODE_RUN;
    cpu_halt = 1'b0;
    h        = (halt_off > 0) ? r + halt_off : (1 << 30);
    for (int o = 1; o <= run_len; o++) begin
      @(negedge clk);
      n = cyc;
      checkOutput("run_cpu_en", int'(cpu_en), (n >= r + SYNC_LAT && n < h) ? 1 : 0);
      checkOutput("run_done",   int'(done),   (n >= h) ? 1 : 0);
      cpu_halt = (o == halt_off);
    end
    z        = cyc + 1;
    mode     = MODE_IDLE;
    cpu_halt = 1'b0;
    for (int o = 0; o < 4; o++) begin
      @(negedge clk);
      n = cyc;
      checkOutput("leave_cpu_en", int'(cpu_en), (n < z + SYNC_LAT && n < h) ? 1 : 0);
      checkOutput("leave_done",   int'(done),   (n < z + SYNC_LAT && n >= h) ? 1 : 0);
    end
  endtask

  // Start a load, assert reset part-way through, expect silence afterwards
  task automatic resetDuringLoad(input logic [1:0] m, input int cut);
    int r, pre, b, pos;
    idleCycles(4);
    we_q.delete();
    @(negedge clk);
    r    = cyc + 1;
    mode = m;
    mosi = 1'b0;
    for (int o = 1; o <= cut; o++) begin
      @(negedge clk);
      b    = (o - 1) % FRAME_BITS;
      mosi = (b < DATA_W) ? frame_data[(o - 1) / FRAME_BITS][DATA_W-1-b] : 1'b0;
    end
    @(negedge clk);
    pos = cyc - r - SYNC_LAT - DATA_W;
    checkOutput("pre_reset_mem_we", int'(mem_we), (pos >= 0 && pos % FRAME_BITS == 0) ? 1 : 0);
    #2;
    rst  = 1'b1;
    mode = MODE_IDLE;
    mosi = 1'b0;
    pre  = we_q.size();
    #1;
    checkAllZero("reset_mid_load");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idleCycles(20);
    checkOutput("writes_after_reset", we_q.size(), pre);
    checkOutput("done_after_reset", int'(done), 0);
  endtask

  initial begin
    int r, m_i, nf, k;
    rst      = 1'b1;
    mode     = MODE_IDLE;
    mosi     = 1'b0;
    cpu_halt = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Single-word loads, one frame each
    vecs[0] = '{MODE_LOAD_I, 8'hA5, 1'b0, 8'hA5, 10};
    vecs[1] = '{MODE_LOAD_D, 8'h3C, 1'b1, 8'h3C, 10};
    vecs[2] = '{MODE_LOAD_I, 8'hFF, 1'b0, 8'hFF, 10};
    vecs[3] = '{MODE_LOAD_D, 8'h01, 1'b1, 8'h01, 10};
    for (int v = 0; v < 4; v++) begin
      frame_data[0] = vecs[v].word;
      applyStimulus(vecs[v].mode, 1, 0, r);
      if (we_q.size() > 0) begin
        checkOutput($sformatf("vec%0d_sel", v), int'(we_q[0].sel), int'(vecs[v].exp_sel));
        checkOutput($sformatf("vec%0d_addr", v), int'(we_q[0].addr), 0);
        checkOutput($sformatf("vec%0d_data", v), int'(we_q[0].data), int'(vecs[v].exp_data));
        checkOutput($sformatf("vec%0d_latency", v), we_q[0].cyc - r, vecs[v].exp_lat);
      end
    end

    // Full data memory load 0x00..0x0F, then done
    for (int i = 0; i < DEPTH; i++) frame_data[i] = DATA_W'(i);
    applyStimulus(MODE_LOAD_D, DEPTH, 0, r);

    // Abort after 3 bits of frame 2, then a fresh session restarts at address 0
    for (int i = 0; i < DEPTH; i++) frame_data[i] = DATA_W'(8'h50 + i);
    applyStimulus(MODE_LOAD_I, 3, 2 * FRAME_BITS + 1 + 3, r);
    frame_data[0] = 8'hC3;
    applyStimulus(MODE_LOAD_I, 1, 0, r);

    // Mode change landing on frame 1's write cycle vs one cycle earlier
    for (int i = 0; i < DEPTH; i++) frame_data[i] = DATA_W'(8'h90 + i);
    applyStimulus(MODE_LOAD_I, 3, FRAME_BITS + 9, r);
    applyStimulus(MODE_LOAD_D, 3, FRAME_BITS + 8, r);
    // Same boundary on the final word of a full load
    applyStimulus(MODE_LOAD_D, DEPTH, FRAME_BITS * (DEPTH - 1) + 9, r);

    // Run control
    runCpu(20, 26);
    runCpu(0, 12);

    // Reset mid-SHIFT, on a write cycle, and while running
    frame_data[0] = 8'hFF;
    frame_data[1] = 8'hE7;
    resetDuringLoad(MODE_LOAD_D, 6);
    resetDuringLoad(MODE_LOAD_I, SYNC_LAT + DATA_W + FRAME_BITS);
    idleCycles(4);
    @(negedge clk);
    mode = MODE_RUN;
    repeat (6) @(negedge clk);
    checkOutput("pre_reset_cpu_en", int'(cpu_en), 1);
    #2;
    rst  = 1'b1;
    mode = MODE_IDLE;
    #1;
    checkAllZero("reset_mid_run");
    @(negedge clk);
    rst = 1'b0;

    // Randomised sessions
    for (int t = 0; t < 6; t++) begin
      m_i = int'($urandom_range(1, 2));
      nf  = (t == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
      k   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FRAME_BITS * nf)) : 0;
      for (int i = 0; i < DEPTH; i++) frame_data[i] = DATA_W'($urandom);
      applyStimulus(2'(m_i), nf, k, r);
    end
    for (int t = 0; t < 3; t++) begin
      k = int'($urandom_range(3, 30));
      runCpu(k, k + int'($urandom_range(2, 8)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_ctrl.md
LOAD_CTRL -- requirements
Module: load_ctrl

Interface
REQ-001 Parameter: ADDR_W, 4, memory address width; memory depth is 2**ADDR_W words.
REQ-002 Parameter: DATA_W, 8, memory word width and serial frame length in bits.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mode  input  2  operating mode: 00 IDLE, 01 LOAD_INSTR, 10 LOAD_DATA, 11 RUN.
REQ-006 mosi  input  1  serial load data, MSB first, one bit per clk while in a load mode.
REQ-007 cpu_halt  input  1  processor reports halt; level, sampled each clk.
REQ-008 mem_we  output  1  one-cycle write strobe to the selected memory.
REQ-009 mem_sel  output  1  write target: 0 instruction memory, 1 data memory.
REQ-010 mem_addr  output  ADDR_W  write address.
REQ-011 mem_wdata  output  DATA_W  assembled write word.
REQ-012 cpu_en  output  1  processor run enable.
REQ-013 done  output  1  load complete or program halted.

Function
REQ-014 States SHALL be IDLE, SHIFT, WRITE, LDONE, RUN and HALTED, held in a registered FSM.
REQ-015 mode and mosi SHALL each pass through a 2-flop synchronizer; all mode decisions use the synchronized mode (m_s).
REQ-016 IDLE: when m_s is 01 or 10, go to SHIFT with bit_cnt=0 and addr=0, and latch mem_sel=m_s[1]; when m_s is 11, go to RUN; otherwise stay in IDLE.
REQ-017 SHIFT: each clk, shift the synchronized mosi into shreg LSB-side and increment bit_cnt; on the DATA_W-th bit, go to WRITE.
REQ-018 WRITE: for exactly one cycle, drive mem_we=1, mem_wdata=shreg and mem_addr=addr.
REQ-019 WRITE exit: if addr == 2**ADDR_W-1, go to LDONE; otherwise increment addr, clear bit_cnt and return to SHIFT.
REQ-020 Latency: the first bit of a frame sampled in SHIFT gives mem_we exactly DATA_W cycles later.
REQ-021 A bit present during the WRITE cycle SHALL be ignored; the host inserts one idle bit per frame.
REQ-022 LDONE: done=1 while m_s is unchanged; any change of m_s returns the FSM to IDLE.
REQ-023 Abort: a change of m_s during SHIFT or WRITE SHALL return the FSM to IDLE without a write.
REQ-024 Abort: on that change, bit_cnt and addr are cleared and earlier written words stay intact.
REQ-025 Abort: if the change coincides with the WRITE cycle, that write SHALL still complete.
REQ-026 RUN: cpu_en=1; when cpu_halt=1, go to HALTED with cpu_en=0 in the next cycle.
REQ-027 RUN: if m_s leaves 11, go to IDLE with cpu_en=0.
REQ-028 HALTED: done=1 and cpu_en=0; leave only when m_s leaves 11, going to IDLE.
REQ-029 addr SHALL never wrap past 2**ADDR_W-1 within one load session.
REQ-030 mem_we, cpu_en and done SHALL be registered (glitch-free) outputs.

Reset
REQ-031 While rst=1, the FSM SHALL be IDLE, and shreg, bit_cnt, addr and the synchronizers SHALL be 0.
REQ-032 While rst=1, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, cpu_en=0 and done=0.
REQ-033 Reset asserted mid-load or mid-run SHALL abort immediately, with no partial write.

Structure
REQ-034 A shared package SHALL hold the mode encodings (MODE_IDLE, MODE_LOAD_I, MODE_LOAD_D, MODE_RUN).
REQ-035 The shared package SHALL also hold the state enum and the default ADDR_W/DATA_W.
REQ-036 One sub-module, sync2, SHALL implement the 2-flop synchronizer and be instantiated per synchronized input.

Verification
REQ-037 Reset scenario: assert rst mid-SHIFT -> all outputs 0 within the same cycle, FSM in IDLE, no mem_we afterwards.
REQ-038 Single-word load: mode=01, serial 8'hA5 -> one mem_we with mem_sel=0, mem_addr=0, mem_wdata=8'hA5, DATA_W cycles after the first bit.
REQ-039 Full data load: mode=10, 16 frames 8'h00..8'h0F -> 16 writes at addr 0..15, mem_sel=1, then done=1; addr never returns to 0.
REQ-040 Abort: mode 01 changed to 00 after 3 bits of frame 2 -> no write for frame 2, IDLE, done=0; re-entering 01 restarts at addr 0.
REQ-041 Run scenario: mode=11 -> cpu_en=1; cpu_halt pulsed at cycle 20 -> cpu_en=0 and done=1 next cycle; mode=00 -> done=0.
REQ-042 Boundary scenario: mode change on the WRITE cycle -> that write still completes, then IDLE.
